// File: rtl/rvx_if_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, bubble word,
// fetch-packet layout and the fetch state encoding.
package rvx_if_pkg;

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  // addi x0,x0,0 -- decoded downstream as a harmless I-type
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  // Fetch packet: {bp, pc, instr}
  localparam int PKT_W        = 65;
  localparam int PKT_BP       = 64;
  localparam int PKT_PC_LSB   = 32;
  localparam int PKT_INST_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/if_bp_predecode.sv
// Static branch predecode: instr + pc -> {bp, next_pc}.
// Macro STAGE_IF_BTFN_EN enables backward-taken/forward-not-taken prediction;
// without it every instruction falls through to pc+4 with bp=0.
module if_bp_predecode
  import rvx_if_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        bp_o,
  output logic [31:0] next_pc_o
);

  // Keeps lint quiet about instruction bits the fall-through build ignores.
  logic unused_instr;
  assign unused_instr = ^instr_i;

`ifdef STAGE_IF_BTFN_EN
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign j_imm = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign b_imm = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};

  // JAL always taken; conditional branches taken only when the offset is negative.
  always_comb begin
    bp_o      = 1'b0;
    next_pc_o = pc_i + 32'd4;
    if (instr_i[6:0] == OP_JAL) begin
      bp_o      = 1'b1;
      next_pc_o = pc_i + j_imm;
    end else if (instr_i[6:0] == OP_BRANCH && instr_i[31]) begin
      bp_o      = 1'b1;
      next_pc_o = pc_i + b_imm;
    end
  end
`else
  assign bp_o      = 1'b0;
  assign next_pc_o = pc_i + 32'd4;
`endif

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, drives the req/ack imem port, buffers
// one response across a stall and emits {bp, pc, instr} packets.
// Optional macro: STAGE_IF_BTFN_EN (static prediction, see if_bp_predecode).
module stage_if
  import rvx_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = rvx_if_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              stop,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [PKT_W-1:0]  inst,
  output logic              err
);

  localparam logic [PKT_W-1:0] BUBBLE = {1'b0, 32'h0, NOP_INST};

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       hbuf_q, hbuf_d;
  logic [PKT_W-1:0]  inst_q, inst_d;
  logic              req_q, req_d;
  logic              err_q, err_d;

  logic [31:0]       pd_instr;
  logic              pd_bp;
  logic [31:0]       pd_next;

  // The buffered word belongs to pc_q: the PC only advances when it is emitted.
  assign pd_instr = (state_q == S_HOLD) ? hbuf_q : imem_rdata;

  if_bp_predecode u_predecode (
    .instr_i   (pd_instr),
    .pc_i      (pc_q),
    .bp_o      (pd_bp),
    .next_pc_o (pd_next)
  );

  // Next-state, PC and packet selection; kill overrides stop, stop overrides ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    hbuf_d  = hbuf_q;
    err_d   = 1'b0;
    if (kill) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      inst_d = BUBBLE;
      hbuf_d = '0;
      err_d  = |redirect_pc[1:0];
      // An unanswered request must still be drained before the new PC is used.
      if ((state_q == S_REQ || state_q == S_FLUSH) && !imem_ack) state_d = S_FLUSH;
      else                                                        state_d = S_REQ;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            if (stop) begin
              hbuf_d  = imem_rdata;
              state_d = S_HOLD;
            end else begin
              inst_d = {pd_bp, pc_q, imem_rdata};
              pc_d   = pd_next;
            end
          end else if (!stop) begin
            inst_d = BUBBLE;
          end
        end
        S_HOLD: begin
          if (!stop) begin
            inst_d  = {pd_bp, pc_q, hbuf_q};
            pc_d    = pd_next;
            state_d = S_REQ;
          end
        end
        S_FLUSH: if (imem_ack) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
    req_d  = (state_d == S_REQ) || (state_d == S_FLUSH);
    // While flushing the stale address stays on the bus until its ack.
    addr_d = (state_d == S_FLUSH) ? addr_q : pc_d;
  end

  // Registered state and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      hbuf_q  <= '0;
      inst_q  <= BUBBLE;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      hbuf_q  <= hbuf_d;
      inst_q  <= inst_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign inst      = inst_q;
  assign err       = err_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: a memory responder, a transaction-level fetch
// model (expected PC, pending packet queue) and literal spot checks.
module tb_stage_if;
  import rvx_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset, kill, stop, imem_ack, imem_req, err;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic [64:0] inst;

  localparam logic [64:0] BUBBLE = {1'b0, 32'h0, 32'h0000_0013};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_if #(.RESET_PC(32'h0), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .kill(kill), .stop(stop), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .err(err)
  );

  // Model state
  logic [31:0] m_pc;
  logic        m_discard, m_held, m_err;
  logic [64:0] m_inst;
  logic [64:0] pend_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hFE00_0EE3;       // beq x0,x0,-4
    if (a == 32'h20) return 32'h0080_006F;       // jal x0,+8
    return 32'h0000_0093 | (((a >> 2) & 32'hFFF) << 20);  // addi x1,x0,a/4
  endfunction

  // {bp, next_pc} from the prediction rules, using shift/mask arithmetic.
  function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] off;
    off = 32'h0;
`ifdef STAGE_IF_BTFN_EN
    if ((w & 32'h7F) == 32'd111) begin
      off = ((w >> 20) & 32'h7FE) | (((w >> 20) & 32'h1) << 11) | (w & 32'hFF000);
      if (w[31]) off = off | 32'hFFF0_0000;
      return {1'b1, pc + off};
    end
    if ((w & 32'h7F) == 32'd99 && w[31]) begin
      off = ((w >> 7) & 32'h1E) | ((w >> 20) & 32'h7E0) | ((w << 4) & 32'h800) | 32'hFFFF_F000;
      return {1'b1, pc + off};
    end
`endif
    return {1'b0, pc + 32'd4 + off};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic k, input logic s, input logic ae,
                      input logic [31:0] rp);
    logic [32:0] pr;
    logic        emit, bub;
    reset = r; kill = k; stop = s; redirect_pc = rp;
    imem_ack   = ae && imem_req;
    imem_rdata = mem_word(imem_addr);
    emit = 1'b0; bub = 1'b0;
    if (r) begin
      pend_q.delete();
      m_pc = 32'h0; m_discard = 1'b0; m_held = 1'b0; m_err = 1'b0; bub = 1'b1;
    end else if (k) begin
      if (m_held) pend_q.delete();
      m_held    = 1'b0;
      m_discard = imem_req && !imem_ack;
      m_pc      = rp & 32'hFFFF_FFFC;
      m_err     = (rp[1:0] != 2'b00);
      bub       = 1'b1;
    end else begin
      m_err = 1'b0;
      if (imem_ack) begin
        if (m_discard) m_discard = 1'b0;
        else begin
          pr = predict(m_pc, imem_rdata);
          pend_q.push_back({pr[32], m_pc, imem_rdata});
          m_pc = pr[31:0];
          if (s) m_held = 1'b1;
          else   emit   = 1'b1;
        end
      end else if (m_held && !s) begin
        m_held = 1'b0;
        emit   = 1'b1;
      end else if (imem_req && !s && !m_discard) begin
        bub = 1'b1;
      end
    end
    if (bub) m_inst = BUBBLE;
    else if (emit) begin
      if (pend_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL model_queue: got empty expected packet");
      end else m_inst = pend_q.pop_front();
    end
    @(posedge clk); #1;
    chk("err", {64'h0, err}, {64'h0, m_err});
    chk("inst", inst, m_inst);
    if (imem_req && !m_discard) chk("imem_addr", {33'h0, imem_addr}, {33'h0, m_pc});
    if (m_held) chk("req_in_hold", {64'h0, imem_req}, 65'h0);
    @(negedge clk);
  endtask

  task automatic run_to(input logic [31:0] a);
    int n;
    n = 0;
    while (imem_addr != a && n < 16) begin
      step(0, 0, 0, 1, 0);
      n++;
    end
    chk("reach_addr", {33'h0, imem_addr}, {33'h0, a});
  endtask

  initial begin
    reset = 1'b1; kill = 1'b0; stop = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    m_pc = '0; m_discard = 1'b0; m_held = 1'b0; m_err = 1'b0; m_inst = BUBBLE;

    // Pin the model against hand-derived values
`ifdef STAGE_IF_BTFN_EN
    chk("pin_beq", {32'h0, predict(32'h10, 32'hFE00_0EE3)}, {32'h0, 1'b1, 32'h0C});
    chk("pin_jal", {32'h0, predict(32'h20, 32'h0080_006F)}, {32'h0, 1'b1, 32'h28});
`else
    chk("pin_beq", {32'h0, predict(32'h10, 32'hFE00_0EE3)}, {32'h0, 1'b0, 32'h14});
    chk("pin_jal", {32'h0, predict(32'h20, 32'h0080_006F)}, {32'h0, 1'b0, 32'h24});
`endif
    chk("pin_addi", {32'h0, predict(32'hFFFF_FFFC, 32'h0000_0093)}, {32'h0, 1'b0, 32'h0});

    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_inst", inst, BUBBLE);
    chk("rst_req",  {64'h0, imem_req}, 65'h0);
    chk("rst_addr", {33'h0, imem_addr}, 65'h0);
    chk("rst_err",  {64'h0, err}, 65'h0);

    step(0, 0, 0, 1, 0);                       // IDLE -> REQ
    chk("idle_req", {64'h0, imem_req}, 65'h1);
    for (int i = 0; i < 4; i++) begin          // 0,4,8,C back to back
      step(0, 0, 0, 1, 0);
      chk("stream_pc",   {33'h0, inst[63:32]}, 65'(4 * i));
      chk("stream_addr", {33'h0, imem_addr}, 65'(4 * i + 4));
      chk("stream_bp",   {64'h0, inst[64]}, 65'h0);
    end
    step(0, 0, 0, 1, 0);                       // beq -4 at 0x10
    chk("beq_pc", {33'h0, inst[63:32]}, 65'h10);
`ifdef STAGE_IF_BTFN_EN
    chk("beq_bp",   {64'h0, inst[64]}, 65'h1);
    chk("beq_addr", {33'h0, imem_addr}, 65'h0C);
`else
    chk("beq_bp",   {64'h0, inst[64]}, 65'h0);
    chk("beq_addr", {33'h0, imem_addr}, 65'h14);
`endif
    step(0, 1, 0, 1, 32'h20);                  // kill with ack: response dropped
    chk("kill_bub",  inst, BUBBLE);
    chk("kill_addr", {33'h0, imem_addr}, 65'h20);
    step(0, 0, 0, 1, 0);                       // jal +8 at 0x20
`ifdef STAGE_IF_BTFN_EN
    chk("jal_bp",   {64'h0, inst[64]}, 65'h1);
    chk("jal_addr", {33'h0, imem_addr}, 65'h28);
`else
    chk("jal_bp",   {64'h0, inst[64]}, 65'h0);
    chk("jal_addr", {33'h0, imem_addr}, 65'h24);
`endif
    run_to(32'h40);
    for (int i = 0; i < 3; i++) begin          // stop on the ack for 0x40
      step(0, 0, 1, 1, 0);
      chk("stall_req", {64'h0, imem_req}, 65'h0);
      chk("stall_pc",  {33'h0, inst[63:32]}, 65'h3C);
    end
    step(0, 0, 0, 1, 0);
    chk("release_pc",   {33'h0, inst[63:32]}, 65'h40);
    chk("release_addr", {33'h0, imem_addr}, 65'h44);
    step(0, 0, 0, 1, 0);
    chk("after_pc", {33'h0, inst[63:32]}, 65'h44);

    run_to(32'h50);
    step(0, 1, 0, 0, 32'h100);                 // kill with 0x50 outstanding
    chk("flush_bub",  inst, BUBBLE);
    chk("flush_addr", {33'h0, imem_addr}, 65'h50);
    chk("flush_req",  {64'h0, imem_req}, 65'h1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);                       // late ack discarded
    chk("drop_bub",  inst, BUBBLE);
    chk("drop_addr", {33'h0, imem_addr}, 65'h100);
    step(0, 0, 0, 1, 0);
    chk("redir_pc", {33'h0, inst[63:32]}, 65'h100);
    step(0, 0, 0, 0, 0);                       // no ack -> bubble
    chk("noack_bub", inst, BUBBLE);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("resume_pc", {33'h0, inst[63:32]}, 65'h104);

    step(0, 1, 0, 1, 32'h102);                 // misaligned redirect
    chk("mis_err",  {64'h0, err}, 65'h1);
    chk("mis_addr", {33'h0, imem_addr}, 65'h100);
    step(0, 0, 0, 1, 0);
    chk("mis_err_clr", {64'h0, err}, 65'h0);
    chk("mis_pc", {33'h0, inst[63:32]}, 65'h100);

    step(0, 1, 0, 1, 32'hFFFF_FFF8);           // wrap-around
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("wrap_pc",   {33'h0, inst[63:32]}, 65'hFFFF_FFFC);
    chk("wrap_addr", {33'h0, imem_addr}, 65'h0);
    step(0, 0, 0, 1, 0);

    step(0, 1, 0, 1, 32'h103);
    step(1, 0, 0, 1, 0);                       // reset mid-request
    chk("rst2_inst", inst, BUBBLE);
    chk("rst2_req",  {64'h0, imem_req}, 65'h0);
    chk("rst2_addr", {33'h0, imem_addr}, 65'h0);
    chk("rst2_err",  {64'h0, err}, 65'h0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("rst2_pc", {33'h0, inst[63:32]}, 65'h0);
    chk("queue_empty", 65'(pend_q.size()), 65'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
- Instruction-fetch stage. Producer of the 65-bit fetch packet consumed by stage_id.
- Packet layout: inst[64] = branch-prediction bit, inst[63:32] = PC, inst[31:0] = instruction word.
- Owns the PC register, drives a request/acknowledge instruction-memory port, and buffers one response across pipeline stalls.
- Applies static backward-taken/forward-not-taken prediction. Obeys the same kill/stop pipeline controls as stage_id.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction word (addi x0,x0,0; stage_id decodes it as I-type, no err).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- kill  in  1  pipeline flush; load redirect_pc.
- stop  in  1  pipeline stall.
- redirect_pc  in  32  new fetch PC; sampled only when kill=1.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  single-cycle response strobe.
- imem_rdata  in  32  instruction word; valid with imem_ack.
- inst  out  65  fetch packet {bp, pc, instr} to stage_id.
- err  out  1  one-cycle pulse: misaligned redirect.

Behaviour:
- Clocking/reset: one clock, clk. reset is synchronous and active-high.
- Reset values: pc_reg=RESET_PC; inst={1'b0,32'h0,NOP_INST}; imem_req=0; err=0; state=IDLE; holding buffer cleared.
- States: IDLE, REQ, HOLD, FLUSH. All outputs are registered; imem_addr=pc_reg.
- IDLE → REQ unconditionally on the next cycle. imem_req=1 in REQ and FLUSH, 0 in IDLE and HOLD.
- REQ, ack=1, stop=0, kill=0:
  - inst <= {bp, pc_reg, imem_rdata}; pc_reg <= next_pc; stay in REQ.
  - Throughput is one instruction per cycle when ack returns every cycle.
- REQ, ack=1, stop=1, kill=0: rdata and pc go into the holding buffer; → HOLD; inst holds.
- REQ, ack=0: inst holds its value. If stop=0, inst <= bubble {0,32'h0,NOP_INST}, so stage_id never re-decodes a stale packet.
- HOLD, stop=1: inst holds. HOLD, stop=0: emit the buffered packet, advance pc_reg, → REQ.
- Priority: kill > stop > ack.
- kill in any state:
  - pc_reg <= {redirect_pc[31:2], 2'b00}; inst <= bubble; holding buffer dropped.
  - Next state: FLUSH if a request is outstanding (REQ and ack=0 this cycle); otherwise REQ.
  - In FLUSH, imem_addr keeps the old address until ack; the response is discarded; then → REQ using the new pc.
  - A kill during FLUSH updates the target pc only; the state stays FLUSH.
- err=1 for exactly one cycle after a kill with redirect_pc[1:0]!=0; otherwise 0.
- next_pc / bp, all adds modulo 2^32, immediates sign-extended:
  - JAL (1101111): bp=1, next=pc+J-imm.
  - B-type (1100011): if instr[31]=1, bp=1, next=pc+B-imm; else bp=0, next=pc+4.
  - JALR and all other opcodes: bp=0, next=pc+4.
- Wrap-around: pc 32'hFFFF_FFFC + 4 = 0, no flag.
- Reset mid-request: the outstanding response is ignored. Memory must tolerate a dropped request, and ack must not arrive while imem_req=0.

Optional Feature:
- STAGE_IF_BTFN_EN defined: static prediction as above.
- Undefined: bp is always 0 and next_pc is always pc+4. JAL/branch redirection comes only through kill from later stages.

Decomposition:
- Package rvx_if_pkg: opcode constants (OP_JAL, OP_BRANCH, OP_JALR), NOP_INST, packet width 65 and field offsets, fetch state enum.
- Sub-module if_bp_predecode: combinational instr+pc → {bp, next_pc}. Immediate extraction and the macro-gated logic live there.

Test Plan:
- Reset, ack every cycle, ADDI stream at RESET_PC=0 → inst PCs 0,4,8… consecutive cycles, bp=0, imem_addr leads by one.
- Fetch 0xFE000EE3 (beq, -4) at pc 0x10 → bp=1, next imem_addr=0x0C. Without STAGE_IF_BTFN_EN → bp=0, addr=0x14.
- Fetch 0x0080006F (jal +8) at pc 0x20 → bp=1, next addr=0x28.
- stop=1 on the ack cycle for pc 0x40, held 3 cycles → inst unchanged, imem_req=0. On release, packet pc=0x40 emitted once, then fetch 0x44.
- kill with redirect_pc=0x100 while request for 0x50 outstanding; ack 2 cycles later → that data discarded, inst=bubble, next imem_addr=0x100.
- kill with redirect_pc=0x102 → err pulses one cycle, fetch from 0x100. Assert reset during REQ → all outputs at reset values next cycle.
